// File: rtl/pulse_burst_sequencer.sv
// pulse_burst_sequencer: registered gate_en train of burst_cnt bursts of burst_len cycles separated by gap_len idle cycles
module pulse_burst_sequencer #(
    parameter int LW = 16,
    parameter int NW = 8,
    parameter int TW = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [LW-1:0] burst_len,
    input  logic [LW-1:0] gap_len,
    input  logic [NW-1:0] burst_cnt,
    output logic          gate_en,
    output logic          burst_start,
    output logic [NW-1:0] burst_idx,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic          cfg_err,
    output logic [TW-1:0] total_pulses
);
    typedef enum logic [1:0] {IDLE, BURST, GAP, DONE} state_t;
    state_t state, state_d;
    logic [LW-1:0] blen, glen, cnt, cnt_d;
    logic [NW-1:0] bcnt;
    logic accept, last, more, active, bs_d;
    assign accept = state == IDLE && start && burst_len != '0 && burst_cnt != '0;
    assign last   = cnt == LW'(1);
    assign more   = burst_idx != bcnt - NW'(1);
    assign active = state == BURST || state == GAP;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_d;
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = accept ? BURST : IDLE;
            BURST:   state_d = abort ? DONE : !last ? BURST : !more ? DONE : glen != '0 ? GAP : BURST;
            GAP:     state_d = abort ? DONE : last ? BURST : GAP;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        bs_d  = state_d == BURST && (state != BURST || last);
        cnt_d = bs_d ? (accept ? burst_len : blen) : state_d == GAP && state != GAP ? glen : cnt - LW'(1);
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            gate_en      <= 1'b0;
            burst_start  <= 1'b0;
            burst_idx    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            cfg_err      <= 1'b0;
            total_pulses <= '0;
            cnt          <= '0;
            blen         <= '0;
            glen         <= '0;
            bcnt         <= '0;
        end else begin
            gate_en      <= state_d == BURST;
            burst_start  <= bs_d;
            busy         <= state_d == BURST || state_d == GAP;
            done         <= state_d == DONE;
            cfg_err      <= state == IDLE && start && !accept;
            cnt          <= cnt_d;
            burst_idx    <= accept ? '0 : bs_d ? burst_idx + NW'(1) : burst_idx;
            total_pulses <= accept ? '0 : gate_en && total_pulses != '1 ? total_pulses + TW'(1) : total_pulses;
            aborted      <= accept ? 1'b0 : active && abort ? 1'b1 : aborted;
            if (accept) begin
                blen <= burst_len;
                glen <= gap_len;
                bcnt <= burst_cnt;
            end
        end
endmodule

// File: tb/tb_pulse_burst_sequencer.sv
// tb_pulse_burst_sequencer: scoreboard bench for pulse_burst_sequencer
module tb_pulse_burst_sequencer;
    logic clk = 0, reset = 1, start = 0, abort = 0;
    logic [15:0] burst_len = 0, gap_len = 0;
    logic [7:0] burst_cnt = 0;
    logic gate_en, burst_start, busy, done, aborted, cfg_err;
    logic [7:0] burst_idx;
    logic [23:0] total_pulses;
    typedef struct {int kind; int cyc; int idx; int total; int ab;} ev_t;
    ev_t q[$];
    ev_t e;
    int tests = 0, fails = 0, cyc = 0, ge_cnt = 0;
    pulse_burst_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .burst_len(burst_len), .gap_len(gap_len), .burst_cnt(burst_cnt),
        .gate_en(gate_en), .burst_start(burst_start), .burst_idx(burst_idx),
        .busy(busy), .done(done), .aborted(aborted), .cfg_err(cfg_err),
        .total_pulses(total_pulses)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask
    task automatic push(input int kind, input int c, input int idx, input int total, input int ab);
        ev_t n;
        n.kind = kind; n.cyc = c; n.idx = idx; n.total = total; n.ab = ab;
        q.push_back(n);
    endtask
    always @(negedge clk) if (!reset) begin
        if (burst_start && burst_idx == 0) ge_cnt = 1;
        else if (gate_en) ge_cnt++;
        if (burst_start || done || cfg_err) begin
            if (q.size() == 0) chk("unexpected_event", cyc, -1);
            else begin
                e = q.pop_front();
                chk("event_kind", burst_start ? 0 : done ? 1 : 2, e.kind);
                chk("event_cycle", cyc, e.cyc);
                if (e.kind == 0) begin
                    chk("bs_idx", burst_idx, e.idx);
                    chk("bs_gate_en", gate_en, 1);
                    chk("bs_busy", busy, 1);
                end else if (e.kind == 1) begin
                    chk("done_total", total_pulses, e.total);
                    chk("done_gate_cycles", ge_cnt, e.total);
                    chk("done_idx", burst_idx, e.idx);
                    chk("done_aborted", aborted, e.ab);
                    chk("done_gate_en", gate_en, 0);
                    chk("done_busy", busy, 0);
                end else begin
                    chk("cfg_busy", busy, 0);
                    chk("cfg_gate_en", gate_en, 0);
                end
            end
        end
    end
    task automatic train(input int bl, input int bc, input int gl, input logic ab_with_start);
        int t, len;
        @(negedge clk);
        t = cyc;
        len = bc * bl + (bc - 1) * gl;
        start = 1; abort = ab_with_start;
        burst_len = 16'(bl); burst_cnt = 8'(bc); gap_len = 16'(gl);
        for (int b = 0; b < bc; b++) push(0, t + 1 + b * (bl + gl), b, 0, 0);
        push(1, t + 1 + len, bc - 1, bl * bc, 0);
        @(negedge clk);
        start = 0; abort = 0;
        burst_len = 7; burst_cnt = 5; gap_len = 1;
        repeat (len + 2) @(negedge clk);
    endtask
    task automatic bad_cfg(input int bl, input int bc);
        @(negedge clk);
        start = 1; burst_len = 16'(bl); burst_cnt = 8'(bc); gap_len = 3;
        push(2, cyc + 1, 0, 0, 0);
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        chk("cfg_no_busy", busy, 0);
    endtask
    initial begin
        int t;
        repeat (2) @(negedge clk);
        chk("rst_gate_en", gate_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_burst_start", burst_start, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_total", total_pulses, 0);
        chk("rst_idx", burst_idx, 0);
        reset = 0;
        train(4, 3, 2, 0);
        train(3, 2, 0, 0);
        bad_cfg(0, 3);
        bad_cfg(5, 0);
        @(negedge clk);
        t = cyc;
        start = 1; burst_len = 10; burst_cnt = 1; gap_len = 0;
        push(0, t + 1, 0, 0, 0);
        push(1, t + 6, 0, 5, 1);
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_gate_low", gate_en, 0);
        repeat (3) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        repeat (2) @(negedge clk);
        chk("aborted_held", aborted, 1);
        train(2, 2, 1, 1);
        chk("aborted_cleared", aborted, 0);
        @(negedge clk);
        t = cyc;
        start = 1; burst_len = 8; burst_cnt = 1; gap_len = 0;
        push(0, t + 1, 0, 0, 0);
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        #2 reset = 1;
        #1;
        chk("async_rst_gate_en", gate_en, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        q.delete();
        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
        train(3, 2, 1, 0);
        @(negedge clk);
        t = cyc;
        start = 1; burst_len = 2; burst_cnt = 1; gap_len = 0;
        push(0, t + 1, 0, 0, 0);
        push(1, t + 3, 0, 2, 0);
        push(0, t + 5, 0, 0, 0);
        push(1, t + 7, 0, 2, 0);
        repeat (5) @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
